adder_seq: RTL and testbench

ADDER_SEQ -- requirements
Module: adder_seq

---
 rtl/adder_seq.sv | 190 +++++++++++++++++++
 tb/tb_adder_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/adder_seq.sv
// Slice-serial adder/subtractor: one SLICE-bit chunk of the operands is
// summed per clock, LSB first, with the result published only on completion.
module adder_seq #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_op1,
   input  logic [WIDTH-1:0] i_op2,
   input  logic             i_carry,
   input  logic             i_sub,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_carry,
   output logic             o_overflow
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   if ((SLICE < 1) || (WIDTH < SLICE) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
      $error("adder_seq: WIDTH must be a positive multiple of SLICE");
   end

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Places a slice result in the top SLICE bits of an otherwise-zero word.
   function automatic logic [WIDTH-1:0] place_top(input logic [SLICE-1:0] s);
      logic [WIDTH-1:0] r;
      r = {WIDTH{1'b0}};
      r[WIDTH-1 -: SLICE] = s;
      return r;
   endfunction

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             accept_s;
   logic             last_slice_s;
   logic [SLICE:0]   slice_sum_s;

   // Start acceptance, last-slice detect and the per-cycle slice adder.
   always_comb begin
      accept_s     = i_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      last_slice_s = (idx_q == IDXW'(NSLICE - 1));
      slice_sum_s  = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]}
                   + {{SLICE{1'b0}}, carry_q};
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; i_start is only honoured outside RUN.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (i_start) state_d = ST_RUN;
            else         state_d = ST_IDLE;
         end
         ST_RUN: begin
            if (last_slice_s) state_d = ST_DONE;
            else              state_d = ST_RUN;
         end
         ST_DONE: begin
            if (i_start) state_d = ST_RUN;
            else         state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Status outputs are decoded from the next state so they leave a flop.
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_IDLE: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
         ST_RUN: begin
            busy_d = 1'b1;
            done_d = 1'b0;
         end
         ST_DONE: begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
            done_d = 1'b0;
         end
      endcase
   end

   // Datapath: operands shift right one slice per RUN cycle so the active
   // slice is always at bit 0, and the work word fills from the top down.
   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      work_d  = work_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      if (accept_s) begin
         a_d     = i_op1;
         b_d     = i_sub ? ~i_op2 : i_op2;
         carry_d = i_sub ? 1'b1 : i_carry;
         idx_d   = {IDXW{1'b0}};
         work_d  = {WIDTH{1'b0}};
      end else if (state_q == ST_RUN) begin
         a_d     = a_q >> SLICE;
         b_d     = b_q >> SLICE;
         carry_d = slice_sum_s[SLICE];
         work_d  = (work_q >> SLICE) | place_top(slice_sum_s[SLICE-1:0]);
         if (last_slice_s) begin
            // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
            sum_d  = work_d;
            cout_d = slice_sum_s[SLICE];
            ovf_d  = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum_s[SLICE-1]
                   ^ slice_sum_s[SLICE];
            idx_d  = idx_q;
         end else begin
            idx_d  = idx_q + IDXW'(1);
         end
      end else begin
         a_d = a_q;
         b_d = b_q;
      end
   end

   // Datapath and result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         work_q  <= {WIDTH{1'b0}};
         carry_q <= 1'b0;
         idx_q   <= {IDXW{1'b0}};
         sum_q   <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         work_q  <= work_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_sum      = sum_q;
   assign o_carry    = cout_q;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_adder_seq.sv
// Scoreboard bench for adder_seq: a 16/4 instance and a degenerate 8/8
// instance, directed vectors with hand-computed results.
module tb_adder_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   always @(posedge clk) cyc <= cyc + 1;

   logic        a_start, a_ci, a_sub, a_busy, a_done, a_c, a_v;
   logic [15:0] a_op1, a_op2, a_sum;
   logic        b_start, b_ci, b_sub, b_busy, b_done, b_c, b_v;
   logic [7:0]  b_op1, b_op2, b_sum;

   adder_seq #(.WIDTH(16), .SLICE(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .i_op1(a_op1), .i_op2(a_op2),
      .i_carry(a_ci), .i_sub(a_sub), .o_busy(a_busy), .o_done(a_done), .o_sum(a_sum),
      .o_carry(a_c), .o_overflow(a_v));

   adder_seq #(.WIDTH(8), .SLICE(8)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .i_op1(b_op1), .i_op2(b_op2),
      .i_carry(b_ci), .i_sub(b_sub), .o_busy(b_busy), .o_done(b_done), .o_sum(b_sum),
      .o_carry(b_c), .o_overflow(b_v));

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
      int          cyc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   logic [17:0] last_a;
   logic [17:0] last_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor for the 16-bit instance: pops on o_done, else checks hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_a = 18'd0;
      end else if (a_done) begin
         if (qa.size() == 0) begin
            check("a_unexpected_done", 32'd1, 32'd0);
         end else begin
            ea = qa.pop_front();
            check("a_sum", {16'd0, a_sum}, {16'd0, ea.sum});
            check("a_carry", {31'd0, a_c}, {31'd0, ea.cout});
            check("a_ovf", {31'd0, a_v}, {31'd0, ea.ovf});
            check("a_latency", cyc, ea.cyc);
            last_a = {ea.sum, ea.cout, ea.ovf};
         end
      end else begin
         check("a_hold", {14'd0, a_sum, a_c, a_v}, {14'd0, last_a});
      end
   end

   // Monitor for the 8-bit single-slice instance.
   always @(negedge clk) begin
      if (!rst_n) begin
         last_b = 18'd0;
      end else if (b_done) begin
         if (qb.size() == 0) begin
            check("b_unexpected_done", 32'd1, 32'd0);
         end else begin
            eb = qb.pop_front();
            check("b_sum", {24'd0, b_sum}, {16'd0, eb.sum});
            check("b_carry", {31'd0, b_c}, {31'd0, eb.cout});
            check("b_ovf", {31'd0, b_v}, {31'd0, eb.ovf});
            check("b_latency", cyc, eb.cyc);
            last_b = {eb.sum, eb.cout, eb.ovf};
         end
      end else begin
         check("b_hold", {14'd0, 8'd0, b_sum, b_c, b_v}, {14'd0, last_b});
      end
   end

   task automatic start_a(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic sb, input logic [15:0] es, input logic ec, input logic ev);
      exp_t e;
      @(negedge clk);
      a_op1 = x; a_op2 = y; a_ci = ci; a_sub = sb; a_start = 1'b1;
      e.sum = es; e.cout = ec; e.ovf = ev; e.cyc = cyc + 1 + 4;
      qa.push_back(e);
      @(negedge clk);
      a_start = 1'b0;
      a_op1 = ~x; a_op2 = ~y; a_ci = ~ci; a_sub = ~sb;
   endtask

   task automatic start_b(input logic [7:0] x, input logic [7:0] y, input logic ci,
                          input logic sb, input logic [7:0] es, input logic ec, input logic ev);
      exp_t e;
      @(negedge clk);
      b_op1 = x; b_op2 = y; b_ci = ci; b_sub = sb; b_start = 1'b1;
      e.sum = {8'd0, es}; e.cout = ec; e.ovf = ev; e.cyc = cyc + 1 + 1;
      qb.push_back(e);
      @(negedge clk);
      b_start = 1'b0;
      b_op1 = ~x; b_op2 = ~y; b_ci = ~ci; b_sub = ~sb;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
      if (qa.size() != 0 || qb.size() != 0) begin
         check(name, qa.size() + qb.size(), 0);
         qa.delete();
         qb.delete();
      end
      repeat (6) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      a_start = 1'b0; a_op1 = 16'd0; a_op2 = 16'd0; a_ci = 1'b0; a_sub = 1'b0;
      b_start = 1'b0; b_op1 = 8'd0;  b_op2 = 8'd0;  b_ci = 1'b0; b_sub = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_a", {12'd0, a_busy, a_done, a_sum, a_c, a_v}, 32'd0);
      check("reset_b", {20'd0, b_busy, b_done, b_sum, b_c, b_v}, 32'd0);
      rst_n = 1'b1;

      start_a(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      check("a_busy_in_run", {31'd0, a_busy}, 32'd1);
      drain("a_timeout_wrap");
      start_a(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      drain("a_timeout_sub");
      start_a(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      drain("a_timeout_ovf");
      start_a(16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
      drain("a_timeout_cin");
      start_a(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
      drain("a_timeout_sub_noborrow");
      start_a(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      drain("a_timeout_sub_ovf");

      // Start while busy: the second request must be ignored.
      start_a(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
      @(negedge clk);
      a_op1 = 16'h4444; a_op2 = 16'h4444; a_start = 1'b1;
      @(negedge clk);
      a_start = 1'b0;
      drain("a_timeout_busy");

      // Back-to-back: start held through DONE re-enters RUN directly.
      begin
         exp_t e1, e2;
         @(negedge clk);
         a_op1 = 16'h1111; a_op2 = 16'h2222; a_ci = 1'b0; a_sub = 1'b0; a_start = 1'b1;
         e1.sum = 16'h3333; e1.cout = 1'b0; e1.ovf = 1'b0; e1.cyc = cyc + 5;
         qa.push_back(e1);
         @(negedge clk);
         a_op1 = 16'hA000; a_op2 = 16'h6000;
         e2.sum = 16'h0000; e2.cout = 1'b1; e2.ovf = 1'b0; e2.cyc = cyc + 9;
         qa.push_back(e2);
         repeat (5) @(negedge clk);
         a_start = 1'b0;
         check("a_b2b_busy", {31'd0, a_busy}, 32'd1);
      end
      drain("a_timeout_b2b");

      // Reset two cycles into RUN aborts the operation silently.
      start_a(16'hAAAA, 16'h5555, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
      @(negedge clk);
      check("a_busy_before_abort", {31'd0, a_busy}, 32'd1);
      rst_n = 1'b0;
      qa.delete();
      #1;
      check("a_abort_outputs", {12'd0, a_busy, a_done, a_sum, a_c, a_v}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      start_a(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
      drain("a_timeout_after_reset");

      start_b(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      drain("b_timeout_80");
      start_b(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
      drain("b_timeout_7f");
      start_b(8'h03, 8'h05, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
      drain("b_timeout_sub");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
